// File: rtl/pico_bus_pkg.sv
// Shared types and constants for the pico bus arbiter.
package pico_bus_pkg;
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_e;

   localparam int PICO_DW = 32;
   localparam int PICO_SW = 4;
   localparam logic [PICO_DW-1:0] PICO_ERR_DATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/pico_rr_pick.sv
// Round-robin picker: first requester at or after ptr, searching upward with wrap.
module pico_rr_pick #(
   parameter int NM = 2,
   parameter int PW = (NM > 1) ? $clog2(NM) : 1
) (
   input  logic [NM-1:0] req,
   input  logic [PW-1:0] ptr,
   output logic [NM-1:0] gnt,
   output logic          any_req
);
   logic [NM-1:0]   rot;
   logic [NM-1:0]   pick;
   logic [2*NM-1:0] dbl_req;
   logic [2*NM-1:0] dbl_pick;

   // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
   always_comb begin
      dbl_req  = {req, req} >> ptr;
      rot      = dbl_req[NM-1:0];
      pick     = '0;
      for (int i = NM - 1; i >= 0; i--) begin
         if (rot[i]) begin
            pick    = '0;
            pick[i] = 1'b1;
         end
      end
      dbl_pick = {pick, pick} << ptr;
      gnt      = dbl_pick[2*NM-1:NM];
      any_req  = |req;
   end
endmodule

// File: rtl/pico_bus_arbiter.sv
// Round-robin arbiter sharing one pico slave port among NM masters,
// one transaction at a time, with a hung-slave response timeout.
module pico_bus_arbiter
   import pico_bus_pkg::*;
#(
   parameter int                 NM       = 2,
   parameter int                 AW       = 8,
   parameter int                 TIMEOUT  = 16,
   parameter logic [PICO_DW-1:0] ERR_DATA = PICO_ERR_DATA
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NM-1:0]         m_valid,
   input  logic [NM*AW-1:0]      m_addr,
   input  logic [NM*PICO_DW-1:0] m_wdata,
   input  logic [NM*PICO_SW-1:0] m_wstrb,
   output logic [NM-1:0]         m_ready,
   output logic [PICO_DW-1:0]    m_rdata,
   output logic                  s_valid,
   output logic [AW-1:0]         s_addr,
   output logic [PICO_DW-1:0]    s_wdata,
   output logic [PICO_SW-1:0]    s_wstrb,
   input  logic                  s_ready,
   input  logic [PICO_DW-1:0]    s_rdata,
   output logic [NM-1:0]         grant,
   output logic                  timeout_err
);
   localparam int PW = (NM > 1) ? $clog2(NM) : 1;
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   arb_state_e    state, state_nx;
   logic [NM-1:0] grant_q, grant_nx, pick;
   logic [PW-1:0] rr_ptr, rr_ptr_nx, g_idx, g_next;
   logic [TW-1:0] timer, timer_nx;
   logic          any_req, busy, aborted, done_ok, to_hit, finish;

   pico_rr_pick #(.NM(NM), .PW(PW)) u_pick (
      .req     (m_valid),
      .ptr     (rr_ptr),
      .gnt     (pick),
      .any_req (any_req)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         grant_q <= '0;
         rr_ptr  <= '0;
         timer   <= '0;
      end else begin
         state   <= state_nx;
         grant_q <= grant_nx;
         rr_ptr  <= rr_ptr_nx;
         timer   <= timer_nx;
      end
   end

   always_comb begin
      g_idx = '0;
      for (int i = 0; i < NM; i++)
         if (grant_q[i]) g_idx = PW'(i);
      g_next = (g_idx == PW'(NM - 1)) ? '0 : g_idx + PW'(1);
   end

   // An abort (owner drops valid) outranks a late s_ready; s_ready outranks expiry.
   assign busy    = (state == BUSY);
   assign aborted = busy && !(|(grant_q & m_valid));
   assign done_ok = busy && !aborted && s_ready;
   assign to_hit  = busy && !aborted && !s_ready && (TIMEOUT > 0) &&
                    (timer == TW'(TIMEOUT - 1));
   assign finish  = done_ok || to_hit || aborted;

   always_comb begin
      state_nx  = state;
      grant_nx  = grant_q;
      rr_ptr_nx = rr_ptr;
      timer_nx  = timer;
      case (state)
         IDLE: begin
            if (any_req) begin
               state_nx = BUSY;
               grant_nx = pick;
               timer_nx = '0;
            end
         end
         BUSY: begin
            if (finish) begin
               state_nx  = IDLE;
               grant_nx  = '0;
               rr_ptr_nx = g_next;
            end else if (TIMEOUT > 0) begin
               timer_nx = timer + TW'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // grant_q is zero in IDLE, so the AND-OR mux drives zeros there.
   always_comb begin
      s_valid     = busy;
      grant       = grant_q;
      s_addr      = '0;
      s_wdata     = '0;
      s_wstrb     = '0;
      for (int i = 0; i < NM; i++) begin
         if (grant_q[i]) begin
            s_addr  |= m_addr[i*AW +: AW];
            s_wdata |= m_wdata[i*PICO_DW +: PICO_DW];
            s_wstrb |= m_wstrb[i*PICO_SW +: PICO_SW];
         end
      end
      m_ready     = (done_ok || to_hit) ? grant_q : '0;
      m_rdata     = done_ok ? s_rdata : (to_hit ? ERR_DATA : '0);
      timeout_err = to_hit;
   end
endmodule

// File: tb/tb_pico_bus_arbiter.sv
// Bench for pico_bus_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_pico_bus_arbiter;
   localparam int NM = 2;
   localparam int AW = 8;
   localparam int TO = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NM-1:0]     m_valid = '0;
   logic [NM*AW-1:0]  m_addr  = '0;
   logic [NM*32-1:0]  m_wdata = '0;
   logic [NM*4-1:0]   m_wstrb = '0;
   logic [NM-1:0]     m_ready, grant;
   logic [31:0]       m_rdata, s_wdata;
   logic [31:0]       s_rdata = '0;
   logic              s_valid, timeout_err;
   logic              s_ready = 1'b0;
   logic [AW-1:0]     s_addr;
   logic [3:0]        s_wstrb;

   int n_chk  = 0;
   int n_fail = 0;

   logic [NM-1:0] exp_seq [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

   pico_bus_arbiter #(.NM(NM), .AW(AW), .TIMEOUT(TO), .ERR_DATA(32'hDEAD_BEEF)) dut (
      .clk(clk), .rst(rst),
      .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_ready(m_ready), .m_rdata(m_rdata),
      .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_ready(s_ready), .s_rdata(s_rdata),
      .grant(grant), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; m_valid = '0; s_ready = 1'b0; m_wstrb = '0;
      cyc(); cyc();
      rst = 1'b0;
   endtask

   // Model state: who owns the slave (-1 none), where the search starts,
   // and how many stalled busy cycles the owner has already spent.
   int md_owner = -1;
   int md_ptr   = 0;
   int md_wait  = 0;

   always @(negedge clk) begin : model
      logic [NM-1:0] e_rdy, e_gnt;
      logic [31:0]   e_rd, e_wd;
      logic [AW-1:0] e_a;
      logic [3:0]    e_ws;
      logic          e_sv, e_to;
      int            nxt, c;
      e_rdy = '0; e_gnt = '0; e_rd = '0; e_wd = '0; e_a = '0; e_ws = '0;
      e_sv = 1'b0; e_to = 1'b0;
      nxt = md_owner;
      if (rst) begin
         nxt = -1; md_ptr = 0; md_wait = 0;
      end else if (md_owner < 0) begin
         for (int k = 0; k < NM; k++) begin
            c = (md_ptr + k) % NM;
            if (nxt < 0 && m_valid[c]) nxt = c;
         end
         md_wait = 0;
      end else begin
         e_sv = 1'b1;
         e_gnt[md_owner] = 1'b1;
         e_a  = m_addr[md_owner*AW +: AW];
         e_wd = m_wdata[md_owner*32 +: 32];
         e_ws = m_wstrb[md_owner*4 +: 4];
         if (!m_valid[md_owner]) begin
            nxt = -1;
         end else if (s_ready) begin
            e_rdy[md_owner] = 1'b1; e_rd = s_rdata; nxt = -1;
         end else if (md_wait + 1 == TO) begin
            e_rdy[md_owner] = 1'b1; e_rd = 32'hDEAD_BEEF; e_to = 1'b1; nxt = -1;
         end else begin
            md_wait++;
         end
         if (nxt < 0) md_ptr = (md_owner + 1) % NM;
      end
      chk("model_s_valid", s_valid, e_sv);
      chk("model_grant", grant, e_gnt);
      chk("model_m_ready", m_ready, e_rdy);
      chk("model_m_rdata", m_rdata, e_rd);
      chk("model_timeout_err", timeout_err, e_to);
      chk("model_s_addr", s_addr, e_a);
      chk("model_s_wdata", s_wdata, e_wd);
      chk("model_s_wstrb", s_wstrb, e_ws);
      chk("ready_at_most_one", $countones(m_ready) <= 1, 1);
      md_owner = nxt;
   end

   initial begin : stim
      int got;
      int pct;
      logic [NM-1:0] rdy_seen;

      // Reset values while rst is held.
      cyc(); cyc();
      chk("rst_s_valid", s_valid, 0);
      chk("rst_grant", grant, 0);
      chk("rst_m_ready", m_ready, 0);
      chk("rst_timeout_err", timeout_err, 0);
      chk("rst_s_addr", s_addr, 0);

      // Single master write, slave ready on second busy cycle.
      do_reset();
      m_valid = 2'b01; m_addr[0 +: 8] = 8'h03; m_wdata[0 +: 32] = 32'h55; m_wstrb[0 +: 4] = 4'h1;
      smp(); chk("t1_c0_s_valid", s_valid, 0);
      cyc(); smp();
      chk("t1_c1_s_valid", s_valid, 1);
      chk("t1_c1_grant", grant, 2'b01);
      chk("t1_c1_m_ready", m_ready, 0);
      cyc(); s_ready = 1'b1; smp();
      chk("t1_c2_m_ready", m_ready, 2'b01);
      chk("t1_c2_s_addr", s_addr, 8'h03);
      chk("t1_c2_s_wdata", s_wdata, 32'h55);
      chk("t1_c2_s_wstrb", s_wstrb, 4'h1);
      cyc(); m_valid = '0; s_ready = 1'b0; smp();
      chk("t1_c3_grant", grant, 0);
      m_valid = 2'b11; s_ready = 1'b1;
      cyc(); smp();
      chk("t1_rr_ptr_grant", grant, 2'b10);
      cyc(); m_valid = '0; s_ready = 1'b0;

      // Contention with a zero-wait slave.
      do_reset();
      m_valid = 2'b11; s_ready = 1'b1; got = 0;
      for (int n = 0; n < 8; n++) begin
         smp();
         if (m_ready != '0) begin
            if (got < 4) chk($sformatf("t2_grant%0d", got), grant, exp_seq[got]);
            got++;
         end
         cyc();
      end
      chk("t2_ready_count", got, 4);
      m_valid = '0; s_ready = 1'b0;

      // Read by master 1.
      do_reset();
      m_valid = 2'b10; m_addr[8 +: 8] = 8'h04; m_wstrb[4 +: 4] = 4'h0;
      s_ready = 1'b1; s_rdata = 32'h0000_00A5;
      smp();
      chk("t3_c0_m_rdata", m_rdata, 0);
      cyc(); smp();
      chk("t3_c1_m_ready", m_ready, 2'b10);
      chk("t3_c1_m_rdata", m_rdata, 32'hA5);
      chk("t3_c1_s_addr", s_addr, 8'h04);
      chk("t3_c1_s_wstrb", s_wstrb, 0);
      cyc(); m_valid = '0; s_ready = 1'b0; smp();
      chk("t3_c2_m_rdata", m_rdata, 0);

      // Timeout expiry on busy cycle 16.
      do_reset();
      m_valid = 2'b01; s_rdata = 32'h1234_5678;
      for (int c = 1; c <= 16; c++) begin
         cyc(); smp();
         if (c == 15) chk("t4_c15_timeout_err", timeout_err, 0);
      end
      chk("t4_c16_m_ready", m_ready, 2'b01);
      chk("t4_c16_m_rdata", m_rdata, 32'hDEAD_BEEF);
      chk("t4_c16_timeout_err", timeout_err, 1);
      cyc(); m_valid = '0; smp();
      chk("t4_c17_s_valid", s_valid, 0);

      // s_ready arriving on the expiry cycle wins.
      do_reset();
      m_valid = 2'b01;
      for (int c = 1; c <= 16; c++) begin
         cyc();
         if (c == 16) s_ready = 1'b1;
         smp();
      end
      chk("t4b_m_ready", m_ready, 2'b01);
      chk("t4b_m_rdata", m_rdata, 32'h1234_5678);
      chk("t4b_timeout_err", timeout_err, 0);
      cyc(); m_valid = '0; s_ready = 1'b0;

      // Master 0 aborts on busy cycle 2; late s_ready ignored.
      do_reset();
      m_valid = 2'b01;
      cyc(); smp(); chk("t5_c1_grant", grant, 2'b01);
      cyc(); m_valid = 2'b10; s_ready = 1'b1; smp();
      chk("t5_c2_m_ready", m_ready, 0);
      chk("t5_c2_m_rdata", m_rdata, 0);
      cyc(); smp(); chk("t5_c3_grant", grant, 0);
      cyc(); smp();
      chk("t5_c4_grant", grant, 2'b10);
      chk("t5_c4_m_ready", m_ready, 2'b10);
      cyc(); m_valid = '0; s_ready = 1'b0;

      // Asynchronous reset in the middle of a busy cycle.
      do_reset();
      m_valid = 2'b01;
      cyc(); #2; rst = 1'b1; #1;
      chk("t6_async_s_valid", s_valid, 0);
      chk("t6_async_grant", grant, 0);
      m_valid = 2'b11;
      cyc(); cyc(); rst = 1'b0;
      cyc(); smp();
      chk("t6_post_grant", grant, 2'b01);
      cyc(); s_ready = 1'b1;
      cyc(); m_valid = '0; s_ready = 1'b0;

      // Randomized traffic; low-ready phases exercise the timeout.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         pct = ((n % 1000) < 300) ? 3 : 40;
         smp(); rdy_seen = m_ready;
         cyc();
         for (int i = 0; i < NM; i++) begin
            if (rdy_seen[i]) begin
               m_valid[i] = 1'b0;
            end else if (m_valid[i] && $urandom_range(0, 199) == 0) begin
               m_valid[i] = 1'b0;
            end else if (!m_valid[i] && $urandom_range(0, 99) < 50) begin
               m_valid[i] = 1'b1;
               m_addr[i*AW +: AW] = AW'($urandom);
               m_wdata[i*32 +: 32] = $urandom;
               m_wstrb[i*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            end
         end
         s_ready = ($urandom_range(0, 99) < pct);
         s_rdata = $urandom;
      end
      smp();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/pico_bus_arbiter.md
Name: pico_bus_arbiter

Overview:
- Shares one pico-style memory-mapped slave port (valid/ready/addr/wdata/wstrb/rdata) between NM requesting masters using round-robin arbitration.
- Sits between the CPU/DMA masters and a CSR slave block. Sequences one transaction at a time.
- Guards against a hung slave with a response-timeout counter that returns an error word.

Parameters:
- NM, 2, number of masters (2..8)
- AW, 8, address width
- TIMEOUT, 16, busy cycles before forced error response; 0 disables the timeout
- ERR_DATA, 32'hDEAD_BEEF, rdata returned on timeout

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- m_valid  in  NM  per-master request
- m_addr  in  NM*AW  packed per-master address; master i occupies [i*AW +: AW]
- m_wdata  in  NM*32  packed write data
- m_wstrb  in  NM*4  packed byte strobes; all zero means read
- m_ready  out  NM  per-master completion, one-cycle pulse
- m_rdata  out  32  read data, broadcast to all masters; valid only with m_ready
- s_valid  out  1  request to slave
- s_addr  out  AW  address to slave
- s_wdata  out  32  write data to slave
- s_wstrb  out  4  byte strobes to slave
- s_ready  in  1  slave completion
- s_rdata  in  32  slave read data
- grant  out  NM  one-hot current owner; all zero when IDLE
- timeout_err  out  1  one-cycle pulse on forced completion

Behaviour:
- Reset (async, immediate): state=IDLE, rr_ptr=0, grant=0, timer=0, s_valid=0, m_ready=0, timeout_err=0. s_addr/s_wdata/s_wstrb=0 while IDLE. Reset mid-transaction drops s_valid at once; the transaction is abandoned with no m_ready.
- States: IDLE, BUSY (enum in package).
- IDLE:
  - If any m_valid is set, pick the first requester at or after rr_ptr, searching upward with wrap.
  - On the next edge: register a one-hot grant, go to BUSY, clear timer.
  - No requests: stay in IDLE.
- BUSY:
  - s_valid=1, registered.
  - s_addr/s_wdata/s_wstrb are combinationally muxed from the granted master. Masters hold their request stable until m_ready.
- Completion: s_ready=1 in BUSY gives, in the same cycle:
  - m_ready[g]=1 and m_rdata=s_rdata.
  - Next edge: state=IDLE, grant=0, rr_ptr=(g+1) mod NM.
- Latency:
  - m_valid seen in IDLE at cycle 0 → s_valid at cycle 1.
  - A zero-wait slave (s_ready in cycle 1) gives m_ready in cycle 1.
  - One IDLE turnaround cycle always separates back-to-back grants, so sustained throughput is at most 1 transaction per 2 cycles.
- Timeout (TIMEOUT>0):
  - timer increments each BUSY cycle without s_ready.
  - When timer==TIMEOUT-1 and s_ready=0: m_ready[g]=1, m_rdata=ERR_DATA, timeout_err=1, all in the same cycle. Then return to IDLE and advance rr_ptr.
  - Width of timer: $clog2(TIMEOUT+1).
- Simultaneous s_ready and timeout expiry: s_ready wins; normal response, no timeout_err.
- Master abort: m_valid[g] dropping while BUSY is a protocol violation.
  - Required handling: return to IDLE next edge, no m_ready, rr_ptr still advances to g+1.
  - A late s_ready in that cycle is ignored.
- m_ready is never asserted to a non-granted master. At most one m_ready bit is set in any cycle.
- m_rdata=0 whenever no m_ready is asserted.
- Requests arriving while BUSY wait. A master holding valid is guaranteed service within NM grants.

Decomposition:
- Package pico_bus_pkg holds:
  - arb_state_e {IDLE, BUSY}
  - PICO_DW=32, PICO_SW=4
  - default ERR_DATA constant
- Sub-module pico_rr_pick: purely combinational.
  - Inputs: req[NM], ptr.
  - Outputs: one-hot gnt[NM] and any_req.
  - Implemented as a rotate, priority-encode, rotate-back.

Test Plan:
- Single master: NM=2, m_valid=01, addr=8'h03, wdata=32'h55, wstrb=4'h1; slave ready on the 2nd BUSY cycle → s_valid from cycle 1; m_ready=01 in cycle 2; grant=01 during BUSY; rr_ptr becomes 1.
- Contention fairness: both masters hold valid for 4 transactions with a zero-wait slave → grant sequence 01,10,01,10; m_ready every 2nd cycle; never two bits set.
- Read path: master 1 reads addr 8'h04 (wstrb=0), slave returns s_rdata=32'h0000_00A5 → m_ready=10, m_rdata=32'hA5; m_rdata=0 on all other cycles.
- Timeout: TIMEOUT=16, s_ready held 0 → m_ready pulses in BUSY cycle 16 with m_rdata=32'hDEADBEEF and timeout_err=1; IDLE next cycle. Second run with s_ready raised on cycle 16 → normal data, no timeout_err.
- Abort and reset: master 0 drops valid in BUSY cycle 2 → IDLE next edge, no m_ready, next grant to master 1. Separately, assert rst mid-BUSY → s_valid and grant go 0 without waiting for a clock edge; after release, the pending request is granted starting at master 0.
